// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch constants and instruction-queue entry types
package fetch_pkg;

  localparam int INST_W   = 64;
  localparam int SLOTS_IN = 10;

  typedef logic [INST_W-1:0] inst_slot_t;

  typedef struct packed {
    inst_slot_t inst;
    logic       jmp;
  } queue_entry_t;

endpackage

// File: rtl/fetch_queue_wr_mux.sv
// rtl/fetch_queue_wr_mux.sv - per-entry write enable and source-slot select for a packet write at tail
module fetch_queue_wr_mux
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SLOTS_IN = fetch_pkg::SLOTS_IN,
  localparam int PW = $clog2(DEPTH),
  localparam int SW = $clog2(SLOTS_IN)
) (
  input  logic [PW-1:0]       tail_i,
  input  logic [3:0]          keep_i,
  output logic [DEPTH-1:0]    wr_en_o,
  output logic [DEPTH*SW-1:0] wr_sel_o
);

  // Compare width wide enough for both the ring offset and the keep count.
  localparam int CW = ((PW > 4) ? PW : 4) + 1;

  // Each entry's distance from tail (mod DEPTH) is the packet slot it would take;
  // the modular subtraction makes the wrap past DEPTH-1 fall out naturally.
  always_comb begin
    logic [PW-1:0] off;
    off      = '0;
    wr_en_o  = '0;
    wr_sel_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      off                  = PW'(e) - tail_i;
      wr_en_o[e]           = (CW'(off) < CW'(keep_i));
      wr_sel_o[e*SW +: SW] = SW'(off);
    end
  end

endmodule

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - fetch instruction queue; optional stall counter under FETCH_QUEUE_STALL_CNT_EN
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SLOTS_IN = fetch_pkg::SLOTS_IN,
  parameter int DEQ_W    = 2,
  parameter int INST_W   = fetch_pkg::INST_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [SLOTS_IN*INST_W-1:0]   i_instTable,
  input  logic [3:0]                   i_keepNum_4,
  input  logic                         i_firstJValid,
  input  logic [2:0]                   i_firstJPos_3,
  input  logic                         i_flush,
  output logic [DEQ_W-1:0]             o_deqValid,
  output logic [DEQ_W*INST_W-1:0]      o_deqInst,
  output logic [DEQ_W-1:0]             o_deqJmp,
  input  logic [$clog2(DEQ_W+1)-1:0]   i_deqNum,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_empty
`ifdef FETCH_QUEUE_STALL_CNT_EN
  ,
  output logic [15:0]                  o_stallCnt_16
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int SW   = $clog2(SLOTS_IN);

  // Storage entries use the package entry type; INST_W overrides must match fetch_pkg::INST_W.
  queue_entry_t mem_q [DEPTH];

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;

  logic [3:0]          keep;
  logic [3:0]          keep_eff;
  logic                enq;
  logic [CNTW-1:0]     deq_eff;
  logic [DEPTH-1:0]    wr_en;
  logic [DEPTH*SW-1:0] wr_sel;
  logic [INST_W-1:0]   slots   [SLOTS_IN];
  logic [INST_W-1:0]   wr_data [DEPTH];
  logic [DEPTH-1:0]    wr_jmp;

  // Readiness only looks at registered occupancy so the producer sees a stable ready.
  assign o_ready = (count_q <= CNTW'(DEPTH - SLOTS_IN));
  assign o_count = count_q;
  assign o_empty = (count_q == '0);

  fetch_queue_wr_mux #(
    .DEPTH    (DEPTH),
    .SLOTS_IN (SLOTS_IN)
  ) u_wr_mux (
    .tail_i   (tail_q),
    .keep_i   (keep),
    .wr_en_o  (wr_en),
    .wr_sel_o (wr_sel)
  );

  // Handshake, clamped keep/dequeue amounts and next pointer/count values.
  always_comb begin
    logic [CNTW-1:0] dn;
    keep     = (i_keepNum_4 > 4'(SLOTS_IN)) ? 4'(SLOTS_IN) : i_keepNum_4;
    enq      = i_valid && o_ready && !i_flush;
    keep_eff = enq ? keep : 4'd0;
    dn       = CNTW'(i_deqNum);
    deq_eff  = (dn > count_q) ? count_q : dn;
    if (deq_eff > CNTW'(DEQ_W)) begin
      deq_eff = CNTW'(DEQ_W);
    end
    head_d  = head_q + PW'(deq_eff);
    tail_d  = tail_q + PW'(keep_eff);
    count_d = count_q + CNTW'(keep_eff) - deq_eff;
  end

  // Route each packet slot to the queue entry chosen by the write mux and tag the jump.
  always_comb begin
    logic [SW-1:0] sel;
    sel = '0;
    for (int k = 0; k < SLOTS_IN; k++) begin
      slots[k] = i_instTable[k*INST_W +: INST_W];
    end
    for (int e = 0; e < DEPTH; e++) begin
      sel        = wr_sel[e*SW +: SW];
      wr_data[e] = (int'(sel) < SLOTS_IN) ? slots[sel] : '0;
      wr_jmp[e]  = i_firstJValid && (int'(sel) == int'(i_firstJPos_3));
    end
  end

  // Pointers and occupancy; flush behaves like a pointer reset but keeps storage.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; only the jump flags are cleared on reset, data is qualified by count.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (rst) begin
        mem_q[e].jmp <= 1'b0;
      end else if (enq && wr_en[e]) begin
        mem_q[e].inst <= wr_data[e];
        mem_q[e].jmp  <= wr_jmp[e];
      end
    end
  end

  // Dequeue window head..head+DEQ_W-1, valid only for occupied entries.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int k = 0; k < DEQ_W; k++) begin
      idx                            = head_q + PW'(k);
      o_deqValid[k]                  = (count_q > CNTW'(k));
      o_deqInst[k*INST_W +: INST_W]  = mem_q[idx].inst;
      o_deqJmp[k]                    = mem_q[idx].jmp;
    end
  end

`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where the producer offered a packet and was refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (i_valid && !o_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stallCnt_16 = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - self-checking bench for fetch_inst_queue against a queue-based model
module tb_fetch_inst_queue;

  localparam int DEPTH    = 16;
  localparam int SLOTS_IN = 10;
  localparam int DEQ_W    = 2;
  localparam int INST_W   = 64;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       i_valid;
  logic                       o_ready;
  logic [SLOTS_IN*INST_W-1:0] i_instTable;
  logic [3:0]                 i_keepNum_4;
  logic                       i_firstJValid;
  logic [2:0]                 i_firstJPos_3;
  logic                       i_flush;
  logic [DEQ_W-1:0]           o_deqValid;
  logic [DEQ_W*INST_W-1:0]    o_deqInst;
  logic [DEQ_W-1:0]           o_deqJmp;
  logic [1:0]                 i_deqNum;
  logic [4:0]                 o_count;
  logic                       o_empty;
`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [15:0]                o_stallCnt_16;
`endif

  typedef struct {
    logic [INST_W-1:0] inst;
    logic              jmp;
  } ent_t;

  ent_t q[$];
  int   stall;
  int   checks;
  int   errors;

  fetch_inst_queue #(
    .DEPTH(DEPTH), .SLOTS_IN(SLOTS_IN), .DEQ_W(DEQ_W), .INST_W(INST_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_instTable   (i_instTable),
    .i_keepNum_4   (i_keepNum_4),
    .i_firstJValid (i_firstJValid),
    .i_firstJPos_3 (i_firstJPos_3),
    .i_flush       (i_flush),
    .o_deqValid    (o_deqValid),
    .o_deqInst     (o_deqInst),
    .o_deqJmp      (o_deqJmp),
    .i_deqNum      (i_deqNum),
    .o_count       (o_count),
    .o_empty       (o_empty)
`ifdef FETCH_QUEUE_STALL_CNT_EN
    ,
    .o_stallCnt_16 (o_stallCnt_16)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int keepn, input logic jv, input int jp,
                       input int dn, input logic fl);
    i_valid       = v;
    i_keepNum_4   = 4'(keepn);
    i_firstJValid = jv;
    i_firstJPos_3 = 3'(jp);
    i_deqNum      = 2'(dn);
    i_flush       = fl;
    for (int k = 0; k < SLOTS_IN; k++) begin
      i_instTable[k*INST_W +: INST_W] = {$urandom(), $urandom()};
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count", 64'(o_count), 64'(sz));
    chk("empty", 64'(o_empty), 64'(sz == 0));
    chk("ready", 64'(o_ready), 64'(sz <= DEPTH - SLOTS_IN));
    for (int k = 0; k < DEQ_W; k++) begin
      chk("deq_valid", 64'(o_deqValid[k]), 64'(k < sz));
      if (k < sz) begin
        chk("deq_inst", o_deqInst[k*INST_W +: INST_W], q[k].inst);
        chk("deq_jmp", 64'(o_deqJmp[k]), 64'(q[k].jmp));
      end
    end
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("stall_cnt", 64'(o_stallCnt_16), 64'(stall));
`endif
  endtask

  // Model: a plain FIFO of entries. Dequeue takes from the pre-edge contents,
  // then an accepted packet appends its first min(keepNum,SLOTS_IN) slots.
  task automatic cycle();
    int   sz;
    int   d;
    int   keep;
    ent_t e;
    @(posedge clk);
    sz = q.size();
    if (rst) begin
      q.delete();
      stall = 0;
    end else begin
      if (i_valid && !(sz <= DEPTH - SLOTS_IN) && stall < 65535) stall++;
      if (i_flush) begin
        q.delete();
      end else begin
        d = int'(i_deqNum);
        if (d > sz) d = sz;
        if (d > DEQ_W) d = DEQ_W;
        repeat (d) void'(q.pop_front());
        if (i_valid && sz <= DEPTH - SLOTS_IN) begin
          keep = (int'(i_keepNum_4) > SLOTS_IN) ? SLOTS_IN : int'(i_keepNum_4);
          for (int j = 0; j < keep; j++) begin
            e.inst = i_instTable[j*INST_W +: INST_W];
            e.jmp  = i_firstJValid && (j == int'(i_firstJPos_3));
            q.push_back(e);
          end
        end
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stall  = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_deq_valid", 64'(o_deqValid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);

    // Full packet, jump at slot 3
    drive(1, 10, 1, 3, 0, 0);
    cycle();
    chk("fill_count", 64'(o_count), 64'd10);
    chk("fill_ready", 64'(o_ready), 64'd0);
    chk("fill_deq_valid", 64'(o_deqValid), 64'b11);
    chk("fill_deq_jmp", 64'(o_deqJmp), 64'b00);
    drive(0, 0, 0, 0, 2, 0);
    cycle();
    chk("jmp_at_slot3", 64'(o_deqJmp), 64'b10);
    repeat (4) cycle();
    chk("drain_count", 64'(o_count), 64'd0);

    // Move pointers to 12, then a packet that wraps past entry 15
    drive(1, 2, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 2, 0);
    cycle();
    drive(1, 7, 1, 5, 0, 0);
    cycle();
    chk("wrap_count", 64'(o_count), 64'd7);
    drive(0, 0, 0, 0, 2, 0);
    repeat (4) cycle();

    // Simultaneous enqueue and dequeue
    drive(1, 4, 0, 0, 0, 0);
    cycle();
    drive(1, 5, 1, 0, 2, 0);
    cycle();
    chk("simul_count", 64'(o_count), 64'd7);
    chk("simul_ready", 64'(o_ready), 64'd0);

    // Flush with a concurrent enqueue and dequeue request
    drive(0, 0, 0, 0, 2, 0);
    cycle();
    drive(1, 4, 0, 0, 0, 0);
    cycle();
    chk("preflush_count", 64'(o_count), 64'd9);
    drive(1, 4, 1, 1, 2, 1);
    cycle();
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_empty", 64'(o_empty), 64'd1);
    chk("flush_deq_valid", 64'(o_deqValid), 64'd0);
    chk("flush_ready", 64'(o_ready), 64'd1);

    // Boundaries: keep=0, over-dequeue, keepNum clamp
    drive(1, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    chk("keep0_count", 64'(o_count), 64'd1);
    drive(0, 0, 0, 0, 2, 0);
    cycle();
    chk("overdeq_count", 64'(o_count), 64'd0);
    drive(0, 0, 0, 0, 3, 0);
    cycle();
    chk("deq_empty_count", 64'(o_count), 64'd0);
    drive(1, 15, 1, 2, 0, 0);
    cycle();
    chk("clamp_count", 64'(o_count), 64'd10);

`ifdef FETCH_QUEUE_STALL_CNT_EN
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    rst = 1'b0;
    drive(1, 10, 0, 0, 0, 0);
    cycle();
    repeat (5) cycle();
    chk("stall_five", 64'(o_stallCnt_16), 64'd5);
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    chk("stall_after_flush", 64'(o_stallCnt_16), 64'd5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("stall_after_rst", 64'(o_stallCnt_16), 64'd0);
`endif

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
